// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-outstanding issue controller between EXU, ALU and writeback (optional counters: ALU_ISSUE_PERF_EN)
module alu_issue_ctrl #(
    parameter int TAG_W = 5,
    parameter int OPC_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    // operation from EXU
    input  logic             req_in_valid_i,
    output logic             req_in_ready_o,
    input  logic [31:0]      req_in_data_a_i,
    input  logic [31:0]      req_in_data_b_i,
    input  logic [OPC_W-1:0] req_in_opcode_i,
    input  logic [TAG_W-1:0] req_tag_i,
    // request to ALU
    output logic             alu_req_valid_o,
    input  logic             alu_req_ready_i,
    output logic [31:0]      alu_req_data_a_o,
    output logic [31:0]      alu_req_data_b_o,
    output logic [OPC_W-1:0] alu_req_opcode_o,
    // result from ALU
    input  logic             alu_rsp_valid_i,
    output logic             alu_rsp_ready_o,
    input  logic [31:0]      alu_rsp_data_i,
    // result toward writeback
    output logic             wb_out_valid_o,
    input  logic             wb_out_ready_i,
    output logic [31:0]      wb_out_data_o,
    output logic [TAG_W-1:0] wb_tag_o,
    // control and status
    input  logic             flush_i,
    output logic             busy_o,
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_busy_o,
    output logic [15:0]      perf_flushed_o
);

    localparam logic [OPC_W-1:0] ALU_NOP = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_WB       = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               drop_q, drop_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        res_q, res_d;
    logic               flush_eff;
    logic               squash_evt;
    logic               done_evt;

    // State and payload registers; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            opc_q   <= ALU_NOP;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opc_q   <= opc_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    // Next state, handshakes and flush handling; a second flush while draining is ignored
    always_comb begin
        state_d         = state_q;
        drop_d          = drop_q;
        a_d             = a_q;
        b_d             = b_q;
        opc_d           = opc_q;
        tag_d           = tag_q;
        res_d           = res_q;
        req_in_ready_o  = 1'b0;
        alu_req_valid_o = 1'b0;
        alu_rsp_ready_o = 1'b0;
        wb_out_valid_o  = 1'b0;
        squash_evt      = 1'b0;
        done_evt        = 1'b0;
        flush_eff       = flush_i && !drop_q;

        unique case (state_q)
            S_IDLE: begin
                req_in_ready_o = !flush_i;
                if (req_in_valid_i && !flush_i) begin
                    a_d     = req_in_data_a_i;
                    b_d     = req_in_data_b_i;
                    opc_d   = req_in_opcode_i;
                    tag_d   = req_tag_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_req_valid_o = 1'b1;
                if (alu_req_ready_i) begin
                    // the ALU has taken the op, so it must be drained rather than dropped
                    state_d = S_WAIT_RSP;
                    if (flush_eff) begin
                        drop_d     = 1'b1;
                        squash_evt = 1'b1;
                    end
                end else if (flush_eff) begin
                    state_d    = S_IDLE;
                    squash_evt = 1'b1;
                end
            end
            S_WAIT_RSP: begin
                alu_rsp_ready_o = 1'b1;
                if (flush_eff) begin
                    drop_d     = 1'b1;
                    squash_evt = 1'b1;
                end
                if (alu_rsp_valid_i) begin
                    res_d   = alu_rsp_data_i;
                    state_d = (drop_q || flush_eff) ? S_IDLE : S_WB;
                end
            end
            S_WB: begin
                wb_out_valid_o = 1'b1;
                if (wb_out_ready_i) begin
                    state_d  = S_IDLE;
                    done_evt = 1'b1;
                end else if (flush_eff) begin
                    state_d    = S_IDLE;
                    squash_evt = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            drop_d = 1'b0;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign alu_req_data_a_o = a_q;
    assign alu_req_data_b_o = b_q;
    assign alu_req_opcode_o = opc_q;
    assign wb_out_data_o    = res_q;
    assign wb_tag_o         = tag_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops_q;
    logic [31:0] perf_busy_q;
    logic [15:0] perf_flushed_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q     <= '0;
            perf_busy_q    <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (done_evt && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (busy_o && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (squash_evt && (perf_flushed_q != '1)) begin
                perf_flushed_q <= perf_flushed_q + 16'd1;
            end
        end
    end

    assign perf_ops_o     = perf_ops_q;
    assign perf_busy_o    = perf_busy_q;
    assign perf_flushed_o = perf_flushed_q;
`else
    logic unused_perf_events;
    assign unused_perf_events = squash_evt ^ done_evt;
    assign perf_ops_o         = '0;
    assign perf_busy_o        = '0;
    assign perf_flushed_o     = '0;
`endif

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

- Initiator-side controller for the ALU `stage_if` handshake.
- Accepts one ALU operation plus a destination tag from the EXU front end and issues it to the ALU on `alu_req`.
- Waits for the ALU result on `alu_rsp` and presents the result with its tag on a writeback `stage_if`.
- Supports a flush that squashes the in-flight operation without violating the ALU handshake.

## Interface
- `TAG_W`, default 5: width of the destination tag carried alongside the operation.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req_in`  `stage_if.slave`  payload `exu_alu_t` (`dataA`, `dataB`, `opcode`): operation from EXU.
- `req_tag`  in  `TAG_W`: tag qualified by `req_in.fire`.
- `alu_req`  `stage_if.master`  payload `exu_alu_t`: request to ALU.
- `alu_rsp`  `stage_if.slave`  payload 32: result from ALU.
- `wb_out`  `stage_if.master`  payload 32: result toward writeback.
- `wb_tag`  out  `TAG_W`: tag qualified by `wb_out.valid`.
- `flush`  in  1: synchronous squash, one-cycle pulse.
- `busy`  out  1: high whenever state is not `S_IDLE`.
- `perf_ops`  out  32: completed (written-back) operations.
- `perf_busy`  out  32: cycles spent outside `S_IDLE`.
- `perf_flushed`  out  16: operations squashed by `flush`.

## Operation
- FSM states: `S_IDLE`, `S_ISSUE`, `S_WAIT_RSP`, `S_WB`. Handshake outputs are Moore, except `req_in.ready`, which is also gated by `flush`.
  - `S_IDLE`: `req_in.ready = !flush`. On `req_in.fire`, register the payload and `req_tag`, then go to `S_ISSUE`.
  - `S_ISSUE`: `alu_req.valid = 1` with the registered payload, held stable until fire. On fire, go to `S_WAIT_RSP`.
  - `S_WAIT_RSP`: `alu_rsp.ready = 1`. On fire, register `alu_rsp.payload`. Go to `S_WB`, or to `S_IDLE` if the drop flag is set.
  - `S_WB`: `wb_out.valid = 1`, payload is the registered result, `wb_tag` is the registered tag. On fire, go to `S_IDLE`.
- Only one operation is outstanding at a time, and no new request is accepted before writeback completes.
- Flush behaviour by state:
  - `S_IDLE`: no request is accepted in that cycle.
  - `S_ISSUE`, `alu_req` not firing that cycle: go to `S_IDLE` and count the operation as flushed.
  - `S_ISSUE`, `alu_req` firing the same cycle: go to `S_WAIT_RSP` with the drop flag set.
  - `S_WAIT_RSP`: set the drop flag. The response is still consumed, because the ALU cannot abort; it is then discarded with no `wb_out.valid`.
  - `S_WB`: if `wb_out` fires that cycle, the operation completes normally. Otherwise `wb_out.valid` falls next cycle, state goes to `S_IDLE`, and the operation counts as flushed.
- The drop flag clears on entry to `S_IDLE`. `flush` is ignored while the drop flag is already set.
- Sequential ops (MUL*/DIV*/REM*) need no special handling; they only extend the time spent in `S_WAIT_RSP`.
- Reset values:
  - State is `S_IDLE`; all valids are 0; `alu_rsp.ready` is 0; `req_in.ready` is 1 after deassertion.
  - Registered payload is `{0, 0, ALU_NOP}`, registered result is 0, `wb_tag` is 0.
  - `busy` is 0; all perf counters are 0; drop flag is 0.
- Reset mid-operation returns immediately to `S_IDLE` and abandons the in-flight operation. The ALU must be reset together with this block.

## Timing
- Request accepted at cycle 0 → `alu_req.valid` from cycle 1.
- ALU result fire at cycle N → `wb_out.valid` from cycle N+1.
- Single-cycle ALU op with all ready signals high:
  - req fire at cycle 0, `alu_req` fire at cycle 1, `alu_rsp` fire at cycle 3, `wb_out` valid at cycle 4.
  - `req_in.ready` returns at cycle 5, so the minimum issue interval is 5 cycles.
- Backpressure on `wb_out` holds `S_WB` indefinitely, with payload and tag stable.
- `busy` is registered-state derived: it rises the cycle after `req_in.fire` and falls the cycle after the final fire or flush exit.

## Configuration
- `ALU_ISSUE_PERF_EN` defined:
  - `perf_ops` increments on `wb_out.fire`, saturating at all-ones.
  - `perf_busy` increments each cycle `busy = 1`, saturating at all-ones.
  - `perf_flushed` increments once per squashed operation, saturating at all-ones.
- `ALU_ISSUE_PERF_EN` undefined: the counters are not built and all perf ports are tied to 0.

## Test plan
- ADD: A=3, B=4, tag=7, all readies high → `wb_out.payload = 7`, `wb_tag = 7`, `wb_out.valid` at cycle 4 after req fire; `perf_ops = 1`.
- DIVU: A=100, B=7 with ALU divider latency → `alu_rsp.ready` held until result; `wb_out.payload = 14`; `req_in.ready` stays 0 throughout.
- `wb_out.ready = 0` for 10 cycles after SUB 5−9 → `wb_out.valid` held, payload stays `32'hFFFFFFFC`, `busy = 1`, and no new request is accepted.
- Flush in `S_WAIT_RSP` during MUL 6×7 → the response (42) is consumed, no `wb_out.valid` ever rises, state returns to `S_IDLE`, `perf_flushed = 1`.
- Flush coincident with `alu_req.fire` → drop flag set, response consumed and discarded, next request (XOR 0xF0^0x0F) writes back `0xFF`.
- `rst_n` asserted in `S_WB` → all valids low immediately; after release `req_in.ready = 1` and counters read 0.
